mem_port_arbiter: RTL

- Shares one single-port unified memory between the CPU instruction-fetch stage (IF) and the data-memory stage (DM).
- Sequences each access as a req/ack transaction on the memory side and generates stall signals back to the pipeline.
- Sits between the pipeline front end and DM stage, and the memory macro, replacing the separate IM/DM instances.
- Data accesses have priority; a fairness counter bounds fetch starvation.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_timer.sv | 31 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding
// and default parameter values.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF        = 16;
    localparam int DATA_W_DEF        = 16;
    localparam int DM_STREAK_MAX_DEF = 4;
    localparam int TIMEOUT_DEF       = 15;

endpackage

// File: rtl/arb_timer.sv
// Busy-state watchdog: cleared on every grant, counts while a transaction is
// outstanding and flags the last permitted cycle.
module arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Holds at LAST so a missing ack cannot wrap the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and the
// data stage; data wins unless it has starved fetch for DM_STREAK_MAX grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int DM_STREAK_MAX = DM_STREAK_MAX_DEF,
    parameter int TIMEOUT       = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              dm_re,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_dm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err_timeout,
    output logic              err_spurious
);

    localparam int SW = $clog2(DM_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(DM_STREAK_MAX);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic          grant_if, grant_dm;
    logic          busy, tmr_expired, finish;
    logic          if_ok, dm_pend;

    assign if_ok   = if_req & ~hlt;
    assign dm_pend = dm_re | dm_we;
    assign busy    = (state != IDLE);
    assign finish  = busy && (mem_ack || tmr_expired);

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (grant_if | grant_dm),
        .run     (busy),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        case (state)
            IDLE: begin
                if (dm_pend && ((streak < STREAK_LIM) || !if_ok)) begin
                    state_nxt = DM_BUSY;
                    grant_dm  = 1'b1;
                    if (!if_ok) begin
                        streak_nxt = '0;
                    end else if (streak != STREAK_LIM) begin
                        streak_nxt = streak + SW'(1);
                    end
                end else if (if_ok) begin
                    state_nxt  = IF_BUSY;
                    grant_if   = 1'b1;
                    streak_nxt = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A timed-out access still completes with zero data so the pipeline moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            if_valid     <= 1'b0;
            dm_rdata     <= '0;
            dm_valid     <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
            if (finish) begin
                mem_req <= 1'b0;
                if (state == IF_BUSY) begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    dm_valid <= 1'b1;
                    if (!mem_ack) begin
                        dm_rdata <= '0;
                    end else if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                    end
                end
            end
            if (busy && !mem_ack && tmr_expired) begin
                err_timeout <= 1'b1;
            end
            if (!busy && mem_ack) begin
                err_spurious <= 1'b1;
            end
        end
    end

    assign stall_if = if_req & ~if_valid;
    assign stall_dm = dm_pend & ~dm_valid;

endmodule
